// File: rtl/da_converter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : da_converter_pkg
// Purpose  : Shared types and constants for the DAC wave player.
// Revision : 1.0 - initial release
// ============================================================================
package da_converter_pkg;

    localparam int DAC_FRAME_W   = 16;
    localparam int DAC_CMD_W     = 4;
    localparam int DEF_RATE_DIV  = 1000;
    localparam int DEF_SCLK_HALF = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_WAIT_TICK = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/da_converter_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : da_converter_spi_tx
// Purpose  : 16-bit MSB-first SPI shift engine, SCLK idles low, data on falls.
// Revision : 1.0 - initial release
// ============================================================================
module da_converter_spi_tx
    import da_converter_pkg::*;
#(
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic [DAC_FRAME_W-1:0] frame_i,
    output logic                   cs_n_o,
    output logic                   sclk_o,
    output logic                   mosi_o,
    output logic                   done_o
);

    localparam int               HW       = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0]    HALF_MAX = HW'(SCLK_HALF - 1);
    localparam logic [3:0]       LAST_BIT = 4'(DAC_FRAME_W - 1);

    logic                   active_q;
    logic                   cs_n_q;
    logic                   sclk_q;
    logic                   mosi_q;
    logic [DAC_FRAME_W-1:0] shreg_q;
    logic [HW-1:0]          hcnt_q;
    logic [3:0]             bitcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            shreg_q  <= '0;
            hcnt_q   <= '0;
            bitcnt_q <= '0;
        end else if (load_i) begin
            active_q <= 1'b1;
            cs_n_q   <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= frame_i[DAC_FRAME_W-1];
            shreg_q  <= frame_i;
            hcnt_q   <= '0;
            bitcnt_q <= '0;
        end else if (active_q) begin
            if (hcnt_q == HALF_MAX) begin
                hcnt_q <= '0;
                sclk_q <= ~sclk_q;
                // A high->low transition is where the next bit is launched
                if (sclk_q) begin
                    if (bitcnt_q == LAST_BIT) begin
                        active_q <= 1'b0;
                        cs_n_q   <= 1'b1;
                        mosi_q   <= 1'b0;
                    end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                        shreg_q  <= {shreg_q[DAC_FRAME_W-2:0], 1'b0};
                        mosi_q   <= shreg_q[DAC_FRAME_W-2];
                    end
                end
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
        end
    end

    // Strobes during the last cycle with cs_n low so the owner can step in lockstep
    assign done_o = active_q && sclk_q && (hcnt_q == HALF_MAX) && (bitcnt_q == LAST_BIT);

    assign cs_n_o = cs_n_q;
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;

endmodule
`default_nettype wire

// File: rtl/da_converter_wave_player.sv
`default_nettype none
// ============================================================================
// Module   : da_converter_wave_player
// Purpose  : Loops over a RAM address window, sending one sample per tick to a SPI DAC.
// Revision : 1.0 - initial release
// ============================================================================
module da_converter_wave_player
    import da_converter_pkg::*;
#(
    parameter int                   ADDR_W    = 10,
    parameter int                   DATA_W    = 32,
    parameter int                   SAMPLE_W  = 12,
    parameter logic [DAC_CMD_W-1:0] DAC_CMD   = 4'h3,
    parameter int                   RATE_DIV  = DEF_RATE_DIV,
    parameter int                   SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear_underrun,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int            CW       = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CW-1:0] RATE_MAX = CW'(RATE_DIV - 1);
    localparam int            GW       = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [GW-1:0] GAP_MAX  = GW'(SCLK_HALF - 1);

    state_t                 state_q;
    logic [ADDR_W-1:0]      ptr_q;
    logic [ADDR_W-1:0]      mem_address_q;
    logic                   mem_cs_q;
    logic [SAMPLE_W-1:0]    sample_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [GW-1:0]          gap_cnt_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   underrun_q;
    logic                   underrun_d;

    logic                   tick_w;
    logic                   load_w;
    logic                   spi_done_w;
    logic [DAC_FRAME_W-1:0] frame_w;
    logic                   unused_readdata_w;

    assign tick_w  = busy_q && (cnt_q == RATE_MAX);
    assign load_w  = (state_q == ST_WAIT_TICK) && enable && tick_w;
    assign frame_w = {DAC_CMD, sample_q};
    assign unused_readdata_w = ^mem_readdata[DATA_W-1:SAMPLE_W];

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE || cnt_q == RATE_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A tick outside WAIT_TICK is lost; a coincident clear must not hide it
    always_comb begin
        underrun_d = underrun_q;
        if (tick_w && (state_q != ST_WAIT_TICK)) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            sample_q      <= '0;
            cnt_q         <= '0;
            gap_cnt_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            underrun_q   <= underrun_d;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ptr_q <= start_addr;
                    if (enable) begin
                        state_q       <= ST_FETCH;
                        busy_q        <= 1'b1;
                        mem_address_q <= start_addr;
                        mem_cs_q      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    mem_cs_q <= 1'b0;
                    state_q  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    sample_q <= mem_readdata[SAMPLE_W-1:0];
                    ptr_q    <= (ptr_q == end_addr) ? start_addr : ptr_q + 1'b1;
                    state_q  <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tick_w) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (spi_done_w) begin
                        state_q      <= ST_GAP;
                        frame_done_q <= 1'b1;
                        gap_cnt_q    <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_MAX) begin
                        if (enable) begin
                            state_q       <= ST_FETCH;
                            mem_address_q <= ptr_q;
                            mem_cs_q      <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    mem_cs_q <= 1'b0;
                end
            endcase
        end
    end

    da_converter_spi_tx #(
        .SCLK_HALF (SCLK_HALF)
    ) u_spi_tx (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_w),
        .frame_i (frame_w),
        .cs_n_o  (dac_cs_n),
        .sclk_o  (dac_sclk),
        .mosi_o  (dac_mosi),
        .done_o  (spi_done_w)
    );

    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_cs_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign underrun       = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_da_converter_wave_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_da_converter_wave_player
// Purpose  : Scoreboard bench: SPI payloads decoded by a monitor, plus directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_da_converter_wave_player;

    logic        clk;
    logic        ra, rb, ena, enb, clra, clrb;
    logic [9:0]  sa, ea, sb, eb;
    logic [9:0]  a_addr, b_addr;
    logic        a_mcs, b_mcs;
    logic [31:0] a_rdata, b_rdata;
    logic        a_cs_n, a_sclk, a_mosi, a_busy, a_fd, a_ur;
    logic        b_cs_n, b_sclk, b_mosi, b_busy, b_fd, b_ur;

    logic [31:0] mem [0:1023];
    logic [15:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          nframes = 0;
    int          csel_cnt = 0;
    logic        count_cs = 1'b0;

    da_converter_wave_player #(.RATE_DIV(100), .SCLK_HALF(2)) u_dut_a (
        .clk(clk), .reset(ra), .enable(ena), .clear_underrun(clra),
        .start_addr(sa), .end_addr(ea), .mem_address(a_addr), .mem_chipselect(a_mcs),
        .mem_readdata(a_rdata), .dac_cs_n(a_cs_n), .dac_sclk(a_sclk), .dac_mosi(a_mosi),
        .busy(a_busy), .frame_done(a_fd), .underrun(a_ur)
    );

    da_converter_wave_player #(.RATE_DIV(40), .SCLK_HALF(2)) u_dut_b (
        .clk(clk), .reset(rb), .enable(enb), .clear_underrun(clrb),
        .start_addr(sb), .end_addr(eb), .mem_address(b_addr), .mem_chipselect(b_mcs),
        .mem_readdata(b_rdata), .dac_cs_n(b_cs_n), .dac_sclk(b_sclk), .dac_mosi(b_mosi),
        .busy(b_busy), .frame_done(b_fd), .underrun(b_ur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_mcs) a_rdata <= mem[a_addr];
        if (b_mcs) b_rdata <= mem[b_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // sel: 0 = dac_cs_n low, 1 = dac_cs_n high, 2 = frame_done high (dut A)
    task automatic wait_for(input int sel, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((sel == 0 && a_cs_n === 1'b0) || (sel == 1 && a_cs_n === 1'b1) ||
                (sel == 2 && a_fd === 1'b1)) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout after %0d cycles, expected event %0d", name, bound, sel);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // SPI monitor: rebuilds each frame from SCLK rising edges and checks it against the scoreboard
    initial begin : g_monitor
        logic [15:0] shreg;
        logic [15:0] exp;
        int          nbits;
        int          lowcnt;
        logic        in_frame;
        logic        prev_csn;
        logic        prev_sclk;
        shreg = '0; nbits = 0; lowcnt = 0; in_frame = 1'b0;
        prev_csn = 1'b1; prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (count_cs && a_mcs) csel_cnt++;
            if (ra) begin
                in_frame = 1'b0;
                nbits    = 0;
            end else begin
                if (prev_csn && !a_cs_n) begin
                    in_frame = 1'b1; nbits = 0; lowcnt = 0; shreg = '0;
                end
                if (in_frame && !a_cs_n) begin
                    lowcnt++;
                    if (a_sclk && !prev_sclk) begin
                        shreg = {shreg[14:0], a_mosi};
                        nbits++;
                    end
                end
                if (in_frame && a_cs_n && !prev_csn) begin
                    in_frame = 1'b0;
                    nframes++;
                    chk("frame_sclk_rises", nbits, 16);
                    chk("frame_cs_low_cycles", lowcnt, 64);
                    chk("frame_done_pulse", a_fd, 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected no frame", shreg);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("frame_payload", shreg, exp);
                    end
                end
            end
            prev_csn  = a_cs_n;
            prev_sclk = a_sclk;
        end
    end

    initial begin : g_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : g_stim
        int e0, t1, t2;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        mem[5]    = 32'h0000_0ABC;
        mem[1023] = 32'hDEAD_B3FF;
        a_rdata = '0; b_rdata = '0;
        ra = 1'b1; rb = 1'b1; ena = 1'b0; enb = 1'b0; clra = 1'b0; clrb = 1'b0;
        sa = '0; ea = '0; sb = 10'd5; eb = 10'd5;
        repeat (3) @(negedge clk);
        chk("rst_mem_address", a_addr, 0);
        chk("rst_chipselect", a_mcs, 0);
        chk("rst_cs_n", a_cs_n, 1);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_frame_done", a_fd, 0);
        chk("rst_underrun", a_ur, 0);
        ra = 1'b0; rb = 1'b0;
        @(negedge clk);

        // single-word loop at address 5
        sa = 10'd5; ea = 10'd5;
        exp_q.push_back(16'h3ABC);
        exp_q.push_back(16'h3ABC);
        ena = 1'b1; e0 = cyc;
        @(negedge clk);
        chk("fetch_address", a_addr, 5);
        chk("fetch_chipselect", a_mcs, 1);
        chk("fetch_busy", a_busy, 1);
        @(negedge clk);
        chk("capture_chipselect", a_mcs, 0);
        wait_for(0, 200, "first_cs_fall");
        t1 = cyc;
        chk("first_frame_latency", t1 - e0, 101);
        wait_for(1, 100, "first_cs_rise");
        wait_for(0, 200, "second_cs_fall");
        t2 = cyc;
        chk("frame_period", t2 - t1, 100);
        wait_for(2, 100, "second_frame_done");
        ena = 1'b0;
        repeat (10) @(negedge clk);
        chk("stop_busy", a_busy, 0);
        chk("stop_cs_n", a_cs_n, 1);

        // window wrapping through 1023 -> 0, then disable mid-SHIFT
        sa = 10'd1022; ea = 10'd1;
        exp_q.push_back(16'h33FE);
        exp_q.push_back(16'h33FF);
        exp_q.push_back(16'h3000);
        exp_q.push_back(16'h3001);
        exp_q.push_back(16'h33FE);
        ena = 1'b1;
        repeat (4) wait_for(2, 200, "wrap_frame_done");
        wait_for(0, 200, "fifth_cs_fall");
        repeat (10) @(negedge clk);
        ena = 1'b0;
        csel_cnt = 0; count_cs = 1'b1;
        wait_for(2, 100, "drop_frame_done");
        repeat (5) @(negedge clk);
        chk("drop_cs_n", a_cs_n, 1);
        chk("drop_busy", a_busy, 0);
        repeat (200) @(negedge clk);
        chk("drop_no_chipselect", csel_cnt, 0);
        count_cs = 1'b0;

        // reset in the middle of a frame (s18: SCLK high, bit 11 of 0x3ABC = 1 on MOSI)
        sa = 10'd5; ea = 10'd5;
        ena = 1'b1;
        wait_for(0, 200, "reset_test_cs_fall");
        repeat (18) @(negedge clk);
        chk("pre_reset_sclk", a_sclk, 1);
        chk("pre_reset_mosi", a_mosi, 1);
        ra = 1'b1; ena = 1'b0;
        @(negedge clk);
        chk("midrst_cs_n", a_cs_n, 1);
        chk("midrst_sclk", a_sclk, 0);
        chk("midrst_mosi", a_mosi, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_chipselect", a_mcs, 0);
        chk("midrst_underrun", a_ur, 0);
        ra = 1'b0;
        repeat (3) @(negedge clk);

        // RATE_DIV=40: ticks at c39 (WAIT), c79 (SHIFT), c119 (WAIT), c159 (SHIFT), c199, c239 (SHIFT)
        enb = 1'b1; e0 = cyc;
        wait_until(e0 + 1 + 60);
        chk("ur_after_first_tick", b_ur, 0);
        wait_until(e0 + 1 + 85);
        chk("ur_after_second_tick", b_ur, 1);
        wait_until(e0 + 1 + 100);
        chk("ur_sticky", b_ur, 1);
        clrb = 1'b1;
        @(negedge clk);
        clrb = 1'b0;
        chk("ur_cleared", b_ur, 0);
        wait_until(e0 + 1 + 165);
        chk("ur_reset_again", b_ur, 1);
        wait_until(e0 + 1 + 200);
        clrb = 1'b1;
        @(negedge clk);
        clrb = 1'b0;
        chk("ur_cleared_2", b_ur, 0);
        wait_until(e0 + 1 + 239);
        clrb = 1'b1;
        @(negedge clk);
        clrb = 1'b0;
        chk("ur_set_beats_clear", b_ur, 1);
        rb = 1'b1; enb = 1'b0;
        @(negedge clk);
        chk("b_rst_underrun", b_ur, 0);
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_cs_n", b_cs_n, 1);
        rb = 1'b0;
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("frames_seen", nframes, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
